card_display_ctrl: RTL
======================

CARD_DISPLAY_CTRL -- requirements
Module: card_display_ctrl

Interface
REQ-001 Parameter ID_BYTES, default 4: number of ASCII ID digits per frame; legal range 1..12.
REQ-002 Parameter TIMEOUT_CYC, default 50_000_000: idle clocks that abort a partial frame; minimum 2.
REQ-003 Parameter INIT_LINE, default 1: scroll index loaded at reset (0..3).
REQ-004 clk  in  1  single system clock; all logic rises on posedge clk.
REQ-005 RST_LCD_N  in  1  asynchronous, active-low reset.
REQ-006 rx_data_in  in  8  received serial byte, valid only when rx_valid=1.
REQ-007 rx_valid  in  1  one-clock strobe: accept rx_data_in this edge.
REQ-008 scroll_event  in  1  one-clock strobe from rotary decoder.
REQ-009 scroll_left  in  1  direction qualifier for scroll_event.
REQ-010 press  in  1  synchronous "home" request, level sampled on clk.
REQ-011 line1_buffer, line2_buffer  out  128 each  16 ASCII chars, char 0 in [127:120].
REQ-012 led_code  out  3  status lamp code.
REQ-013 frame_done  out  1  one-clock pulse per committed good frame.
REQ-014 frame_err  out  1  one-clock pulse per rejected or timed-out frame.

Function
REQ-015 Frame = ID_BYTES ID bytes, then FLAGS, V1, V2; FRAME_LEN = ID_BYTES+3; byte counter 0..FRAME_LEN-1.
REQ-016 States SHALL be IDLE (counter=0), ASSEMBLE (counter>0), DISCARD; rx_valid in IDLE starts ASSEMBLE.
REQ-017 ID byte outside 0x30..0x39 -> DISCARD; DISCARD swallows bytes until counter wraps, then one frame_err pulse, back to IDLE, stored frame untouched.
REQ-018 Accepting the last byte of a clean frame commits ID, FLAGS, V1, V2 atomically on that edge (E), sets valid flag, pulses frame_done in cycle after E.
REQ-019 Idle timer counts clocks without rx_valid while in ASSEMBLE/DISCARD; at TIMEOUT_CYC -> counter=0, IDLE, one frame_err pulse, partial data dropped.
REQ-020 rx_valid on the same edge as timer expiry: byte accepted, timer cleared, no timeout.
REQ-021 Page lines: L0 "STUDENT   ID:   "; L1 "ID: "+ID chars, space-padded/truncated to 16; L2/L3 per REQ-022..024.
REQ-022 No valid frame since reset: L1 "WAITING FOR CARD", L2 "     WAITING    ", L3 "    FOR CARD    ", led_code=3'b111.
REQ-023 FLAGS[0]=1 (entry): L2 "    WELCOME!    ", L3 "   SEAT: "+3 decimal digits of V1+"    "; led_code 101 if ID last char bit0=0, else 011 if bit3=1, else 001.
REQ-024 FLAGS[0]=0 (exit): L2 "    GOODBYE!    ", L3 "TIME : "+2 digits of V1 mod 100+"MIN"+2 digits of V2 mod 100+"S "; led_code 100 / 010 / 000 by same rule.
REQ-025 Most recent rejected/timed-out frame after a good one SHALL leave display unchanged; before any good frame L2 shows " CARD READ ERROR" until next good frame.
REQ-026 Decimal digits: ASCII 0x30+digit, leading zeros shown, computed from committed values only.
REQ-027 Scroll index (2 bits): press -> 0; else scroll_event&scroll_left -> +1; scroll_event&~scroll_left -> -1; wraps 3<->0; press beats scroll.
REQ-028 Outputs registered: index k shows L[k] on line1, L[(k+1) mod 4] on line2; updated edge E+1 after commit or one edge after index change.
REQ-029 frame_done and frame_err never both high in one cycle.

Reset
REQ-030 RST_LCD_N low asynchronously: counter=0, IDLE, timer=0, valid flag=0, stored ID/FLAGS/V1/V2=0, index=INIT_LINE, frame_done=0, frame_err=0, led_code=111.
REQ-031 line buffers reflect REQ-022 page at INIT_LINE from first clock after release; reset mid-frame drops all partial bytes.

Verification
REQ-032 Bytes "1234",01,2A,00 -> frame_done once; index 2 shows "    WELCOME!    "/"   SEAT: 042    "; led_code=101.
REQ-033 Bytes "1235",00,05,1E -> L3 "TIME : 05MIN30S ", L2 "    GOODBYE!    ", led_code=000.
REQ-034 Bytes "12A4",01,01,01 -> one frame_err after 7th byte, display unchanged, next clean frame accepted.
REQ-035 TIMEOUT_CYC=8, send 3 bytes, stop -> frame_err 8 clocks after last byte; fresh 7-byte frame commits; byte on expiry edge prevents timeout.
REQ-036 index 3 + scroll_event&scroll_left -> 0; same-cycle press and scroll_event -> 0; from 0, right scroll -> 3.
REQ-037 Assert RST_LCD_N mid-frame between clocks -> outputs at REQ-030 values immediately; remaining bytes of old frame do not commit.

Source files
------------

// File: rtl/card_display_ctrl.sv
// Card reader display controller: assembles ID/FLAGS/V1/V2 frames from a byte
// stream and renders a scrollable four-line status page plus a status lamp code.
module card_display_ctrl #(
   parameter int ID_BYTES    = 4,
   parameter int TIMEOUT_CYC = 50_000_000,
   parameter int INIT_LINE   = 1
) (
   input  logic         clk,
   input  logic         RST_LCD_N,
   input  logic [7:0]   rx_data_in,
   input  logic         rx_valid,
   input  logic         scroll_event,
   input  logic         scroll_left,
   input  logic         press,
   output logic [127:0] line1_buffer,
   output logic [127:0] line2_buffer,
   output logic [2:0]   led_code,
   output logic         frame_done,
   output logic         frame_err
);
   localparam int FRAME_LEN = ID_BYTES + 3;
   localparam int CW        = $clog2(FRAME_LEN);
   localparam int TW        = $clog2(TIMEOUT_CYC);
   localparam int IDW       = ID_BYTES * 8;
   localparam logic [CW-1:0] LAST  = CW'(FRAME_LEN - 1);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {S_IDLE, S_ASSEMBLE, S_DISCARD} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [TW-1:0]   tmr_q, tmr_d;
   logic [IDW-1:0]  id_sh_q, id_sh_d;
   logic            ent_sh_q, ent_sh_d;
   logic [7:0]      v1_sh_q, v1_sh_d;
   logic [IDW-1:0]  id_q, id_d;
   logic            ent_q, ent_d;
   logic [7:0]      v1_q, v1_d;
   logic [7:0]      v2_q, v2_d;
   logic            valid_q, valid_d;
   logic            err_q, err_d;
   logic            done_q, done_d;
   logic            ferr_q, ferr_d;
   logic [1:0]      idx_q, idx_d;
   logic [127:0]    l1_q, l1_d, l2_q, l2_d;
   logic [2:0]      led_q, led_d;

   function automatic logic is_digit(input logic [7:0] b);
      return (b >= 8'h30) && (b <= 8'h39);
   endfunction

   function automatic logic [23:0] dec3(input logic [7:0] v);
      logic [7:0] h, t, o;
      h = v / 8'd100;
      t = (v / 8'd10) % 8'd10;
      o = v % 8'd10;
      return {8'h30 + h, 8'h30 + t, 8'h30 + o};
   endfunction

   function automatic logic [15:0] dec2(input logic [7:0] v);
      logic [7:0] m;
      m = v % 8'd100;
      return {8'h30 + m / 8'd10, 8'h30 + m % 8'd10};
   endfunction

   // Char 0 of a line sits in [127:120]; ID byte j is held in id[8j +: 8].
   function automatic logic [127:0] page_line(input logic [1:0] k, input logic vld,
                                              input logic err, input logic [IDW-1:0] id,
                                              input logic ent, input logic [7:0] a,
                                              input logic [7:0] b);
      logic [127:0] s;
      s = "STUDENT   ID:   ";
      case (k)
         2'd1: begin
            if (vld) begin
               s = {"ID: ", {12{8'h20}}};
               for (int j = 0; j < ID_BYTES; j++) s[8*(11-j) +: 8] = id[8*j +: 8];
            end else begin
               s = "WAITING FOR CARD";
            end
         end
         2'd2: begin
            if (vld)      s = ent ? "    WELCOME!    " : "    GOODBYE!    ";
            else if (err) s = " CARD READ ERROR";
            else          s = "     WAITING    ";
         end
         2'd3: begin
            if (!vld)     s = "    FOR CARD    ";
            else if (ent) s = {"   SEAT: ", dec3(a), "    "};
            else          s = {"TIME : ", dec2(a), "MIN", dec2(b), "S "};
         end
         default: ;
      endcase
      return s;
   endfunction

   function automatic logic [2:0] led_fn(input logic vld, input logic ent,
                                         input logic last_b0, input logic last_b3);
      logic [2:0] c;
      if (!vld)         c = 3'b111;
      else if (!last_b0) c = {2'b10, ent};
      else if (last_b3)  c = {2'b01, ent};
      else               c = {2'b00, ent};
      return c;
   endfunction

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      tmr_d    = tmr_q;
      id_sh_d  = id_sh_q;
      ent_sh_d = ent_sh_q;
      v1_sh_d  = v1_sh_q;
      id_d     = id_q;
      ent_d    = ent_q;
      v1_d     = v1_q;
      v2_d     = v2_q;
      valid_d  = valid_q;
      err_d    = err_q;
      done_d   = 1'b0;
      ferr_d   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (rx_valid) begin
               cnt_d = CW'(1);
               id_sh_d[7:0] = rx_data_in;
               state_d = is_digit(rx_data_in) ? S_ASSEMBLE : S_DISCARD;
            end
         end
         default: begin
            if (rx_valid) begin
               tmr_d = '0;
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  state_d = S_IDLE;
                  if (state_q == S_ASSEMBLE) begin
                     // V2 is the final byte, so it commits straight from the input.
                     id_d    = id_sh_q;
                     ent_d   = ent_sh_q;
                     v1_d    = v1_sh_q;
                     v2_d    = rx_data_in;
                     valid_d = 1'b1;
                     done_d  = 1'b1;
                  end else begin
                     ferr_d = 1'b1;
                     err_d  = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
                  if (state_q == S_ASSEMBLE) begin
                     if (cnt_q < CW'(ID_BYTES)) begin
                        if (!is_digit(rx_data_in)) state_d = S_DISCARD;
                        for (int j = 0; j < ID_BYTES; j++)
                           if (cnt_q == CW'(j)) id_sh_d[8*j +: 8] = rx_data_in;
                     end else if (cnt_q == CW'(ID_BYTES)) begin
                        ent_sh_d = rx_data_in[0];
                     end else begin
                        v1_sh_d = rx_data_in;
                     end
                  end
               end
            end else if (tmr_q == TLAST) begin
               state_d = S_IDLE;
               cnt_d   = '0;
               tmr_d   = '0;
               ferr_d  = 1'b1;
               err_d   = 1'b1;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
      endcase
   end

   always_comb begin
      idx_d = idx_q;
      if (press)             idx_d = 2'd0;
      else if (scroll_event) idx_d = scroll_left ? idx_q + 2'd1 : idx_q - 2'd1;
      l1_d  = page_line(idx_q, valid_q, err_q, id_q, ent_q, v1_q, v2_q);
      l2_d  = page_line(idx_q + 2'd1, valid_q, err_q, id_q, ent_q, v1_q, v2_q);
      led_d = led_fn(valid_q, ent_q, id_q[IDW-8], id_q[IDW-5]);
   end

   always_ff @(posedge clk or negedge RST_LCD_N) begin
      if (!RST_LCD_N) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         tmr_q    <= '0;
         id_sh_q  <= '0;
         ent_sh_q <= 1'b0;
         v1_sh_q  <= '0;
         id_q     <= '0;
         ent_q    <= 1'b0;
         v1_q     <= '0;
         v2_q     <= '0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
         ferr_q   <= 1'b0;
         idx_q    <= 2'(INIT_LINE);
         l1_q     <= page_line(2'(INIT_LINE), 1'b0, 1'b0, '0, 1'b0, 8'd0, 8'd0);
         l2_q     <= page_line(2'(INIT_LINE + 1), 1'b0, 1'b0, '0, 1'b0, 8'd0, 8'd0);
         led_q    <= 3'b111;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         tmr_q    <= tmr_d;
         id_sh_q  <= id_sh_d;
         ent_sh_q <= ent_sh_d;
         v1_sh_q  <= v1_sh_d;
         id_q     <= id_d;
         ent_q    <= ent_d;
         v1_q     <= v1_d;
         v2_q     <= v2_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         done_q   <= done_d;
         ferr_q   <= ferr_d;
         idx_q    <= idx_d;
         l1_q     <= l1_d;
         l2_q     <= l2_d;
         led_q    <= led_d;
      end
   end

   assign line1_buffer = l1_q;
   assign line2_buffer = l2_q;
   assign led_code     = led_q;
   assign frame_done   = done_q;
   assign frame_err    = ferr_q;

endmodule
